// File: rtl/branch_redirect_ctrl_if.sv
// Resolution interface between the branch predictor and its redirect controller.
// master: the predictor/pipeline side. It drives the prediction, the misprediction
//         report and stall, and it consumes the PC update and the stage-register controls.
// slave : branch_redirect_ctrl. It consumes the predictor signals and drives the
//         PC update and the stage-register controls.
interface branch_redirect_ctrl_if;
  logic [31:0] pred_addr;
  logic        br_hazard;
  logic [31:0] recv_addr;
  logic        do_jump;
  logic        stall;
  logic [31:0] pc_next;
  logic        load_pc;
  logic        load_ifid;
  logic        load_idex;
  logic        ifid_rst;
  logic        idex_rst;
  logic        redirect_pending;

  modport master (
    output pred_addr, br_hazard, recv_addr, do_jump, stall,
    input  pc_next, load_pc, load_ifid, load_idex, ifid_rst, idex_rst,
           redirect_pending
  );

  modport slave (
    input  pred_addr, br_hazard, recv_addr, do_jump, stall,
    output pc_next, load_pc, load_ifid, load_idex, ifid_rst, idex_rst,
           redirect_pending
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: the consumer end of the predictor's resolution path.
// It selects the next PC (the predicted target or the corrected target) and drives
// the IF/ID and ID/EX load and flush controls. A misprediction that arrives while
// the pipeline is stalled is held until the pipeline advances. The block also keeps
// saturating counters of resolved branches and of mispredictions.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   bus (slave)   : pred_addr, br_hazard, recv_addr, do_jump and stall in;
//                   pc_next, load_pc, load_ifid, load_idex, ifid_rst, idex_rst
//                   and redirect_pending out
//   br_count      : resolved branches/jumps (saturating)
//   mispred_count : resolved mispredictions (saturating)
module branch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_redirect_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, next_state;
  logic [31:0] saved_addr, next_saved;
  logic        advance;
  logic        mis_inc;
  logic        loads;
  logic        flush;

  // Every control output is combinational, so a redirect lands on the next edge.
  always_comb begin
    next_state   = state;
    next_saved   = saved_addr;
    bus.pc_next  = bus.pred_addr;
    loads        = 1'b0;
    flush        = 1'b0;
    advance      = 1'b0;
    mis_inc      = 1'b0;
    if (rst) begin
      bus.pc_next = RESET_PC;
      flush       = 1'b1;
      next_state  = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (!bus.stall) begin
            loads   = 1'b1;
            advance = 1'b1;
            if (bus.br_hazard) begin
              bus.pc_next = bus.recv_addr;
              flush       = 1'b1;
              mis_inc     = 1'b1;
            end
          end else if (bus.br_hazard) begin
            // The branch is still in EX, so a flush here would kill it.
            // Save the target and apply it once the pipeline moves again.
            next_saved = bus.recv_addr;
            next_state = HOLD;
          end
        end
        HOLD: begin
          // While the pipeline is held, the hazard inputs repeat the same branch,
          // so saved_addr is the value to use.
          if (!bus.stall) begin
            bus.pc_next = saved_addr;
            loads       = 1'b1;
            flush       = 1'b1;
            advance     = 1'b1;
            mis_inc     = 1'b1;
            next_state  = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign bus.load_pc          = loads;
  assign bus.load_ifid        = loads;
  assign bus.load_idex        = loads;
  assign bus.ifid_rst         = flush;
  assign bus.idex_rst         = flush;
  assign bus.redirect_pending = (state == HOLD) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      saved_addr    <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      state      <= next_state;
      saved_addr <= next_saved;
      // Only advancing cycles count, so each instruction is counted once.
      if (advance) begin
        if (bus.do_jump && (br_count != '1))
          br_count <= br_count + CNT_W'(1);
        if (mis_inc && (mispred_count != '1))
          mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if mif ();
  branch_redirect_ctrl_if sif ();

  logic [31:0] br32, mis32;
  logic [3:0]  br4, mis4;

  branch_redirect_ctrl #(.RESET_PC(32'h0000_0060), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(mif.slave),
    .br_count(br32), .mispred_count(mis32)
  );

  // A second instance with narrow counters sees the same stimulus, so its
  // counters can be checked for saturation.
  assign sif.pred_addr = mif.pred_addr;
  assign sif.br_hazard = mif.br_hazard;
  assign sif.recv_addr = mif.recv_addr;
  assign sif.do_jump   = mif.do_jump;
  assign sif.stall     = mif.stall;

  branch_redirect_ctrl #(.RESET_PC(32'h0000_0060), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sif.slave),
    .br_count(br4), .mispred_count(mis4)
  );

  typedef struct {
    string       nm;
    bit          chk_pc;
    logic [31:0] pc;
    logic        ld;
    logic        fl;
    logic        pd;
    bit          chk_cnt;
    logic [31:0] br;
    logic [31:0] mis;
    bit          chk_sat;
    logic [3:0]  sbr;
    logic [3:0]  smis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string what, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, act, req);
    end
  endtask

  // Monitor: the outputs are valid every cycle once the inputs are settled.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_pc) chk(e.nm, "pc_next", mif.pc_next, e.pc);
      chk(e.nm, "load_pc",   {31'b0, mif.load_pc},   {31'b0, e.ld});
      chk(e.nm, "load_ifid", {31'b0, mif.load_ifid}, {31'b0, e.ld});
      chk(e.nm, "load_idex", {31'b0, mif.load_idex}, {31'b0, e.ld});
      chk(e.nm, "ifid_rst",  {31'b0, mif.ifid_rst},  {31'b0, e.fl});
      chk(e.nm, "idex_rst",  {31'b0, mif.idex_rst},  {31'b0, e.fl});
      chk(e.nm, "pending",   {31'b0, mif.redirect_pending}, {31'b0, e.pd});
      if (e.chk_cnt) begin
        chk(e.nm, "br_count", br32, e.br);
        chk(e.nm, "mispred_count", mis32, e.mis);
      end
      if (e.chk_sat) begin
        chk(e.nm, "sat_br_count", {28'b0, br4}, {28'b0, e.sbr});
        chk(e.nm, "sat_mispred_count", {28'b0, mis4}, {28'b0, e.smis});
      end
    end
  end

  task automatic step(input string nm, input bit r, input bit s, input bit h,
                      input bit dj, input logic [31:0] pred, input logic [31:0] recv,
                      input bit chkpc, input logic [31:0] epc, input bit eld,
                      input bit efl, input bit epd, input bit chkc,
                      input logic [31:0] ebr, input logic [31:0] emis,
                      input bit chks = 1'b0, input logic [3:0] sbr = 4'd0,
                      input logic [3:0] smis = 4'd0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mif.stall = s; mif.br_hazard = h; mif.do_jump = dj;
    mif.pred_addr = pred; mif.recv_addr = recv;
    e.nm = nm; e.chk_pc = chkpc; e.pc = epc; e.ld = eld; e.fl = efl; e.pd = epd;
    e.chk_cnt = chkc; e.br = ebr; e.mis = emis;
    e.chk_sat = chks; e.sbr = sbr; e.smis = smis;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; mif.stall = 1'b0; mif.br_hazard = 1'b0; mif.do_jump = 1'b0;
    mif.pred_addr = '0; mif.recv_addr = '0;

    // name         r s h dj pred          recv          cpc pc           ld fl pd cc br mis
    step("reset0",  1,0,0,0, 32'h0,        32'h0,        1, 32'h60,       0, 1, 0, 0, 0, 0);
    step("reset1",  1,0,0,0, 32'h0,        32'h0,        1, 32'h60,       0, 1, 0, 1, 0, 0);
    // correct prediction
    step("pred_ok", 0,0,0,1, 32'h100,      32'h0,        1, 32'h100,      1, 0, 0, 1, 0, 0);
    step("pred_cnt",0,0,0,0, 32'h104,      32'h0,        1, 32'h104,      1, 0, 0, 1, 1, 0);
    // mispredict without stall
    step("mis",     0,0,1,1, 32'h108,      32'h200,      1, 32'h200,      1, 1, 0, 1, 1, 0);
    step("mis_aft", 0,0,0,0, 32'h204,      32'h0,        1, 32'h204,      1, 0, 0, 1, 2, 1);
    // mispredict under stall; target changes while held
    step("st_run",  0,1,1,1, 32'h208,      32'h300,      0, 32'h0,        0, 0, 0, 1, 2, 1);
    step("hold1",   0,1,1,1, 32'h208,      32'hDEAD,     0, 32'h0,        0, 0, 1, 1, 2, 1);
    step("hold2",   0,1,0,1, 32'h208,      32'hDEAD,     0, 32'h0,        0, 0, 1, 1, 2, 1);
    step("hold3",   0,1,1,1, 32'h208,      32'hDEAD,     0, 32'h0,        0, 0, 1, 1, 2, 1);
    step("release", 0,0,1,1, 32'h20C,      32'hDEAD,     1, 32'h300,      1, 1, 1, 1, 2, 1);
    step("rel_aft", 0,0,0,0, 32'h300,      32'h0,        1, 32'h300,      1, 0, 0, 1, 3, 2);
    // reset while in HOLD
    step("to_hold", 0,1,1,0, 32'h304,      32'h400,      0, 32'h0,        0, 0, 0, 1, 3, 2);
    step("rst_hold",1,1,0,0, 32'h304,      32'h0,        1, 32'h60,       0, 1, 0, 1, 3, 2);
    step("post_rst",0,0,0,0, 32'h500,      32'h0,        1, 32'h500,      1, 0, 0, 1, 0, 0);
    // stall without a hazard
    for (int i = 0; i < 5; i++)
      step("stall_nh",0,1,0,1, 32'h504,    32'h0,        1, 32'h504,      0, 0, 0, 1, 0, 0);
    step("stall_end",0,0,0,0, 32'h508,     32'h0,        1, 32'h508,      1, 0, 0, 1, 0, 0);
    // saturation of the 4-bit instance: 16 advancing mispredicts
    step("sat_rst", 1,0,0,0, 32'h0,        32'h0,        1, 32'h60,       0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++)
      step("sat_mis",0,0,1,1, 32'h600,     32'h1000 + 32'(i) * 4, 1, 32'h1000 + 32'(i) * 4,
           1, 1, 0, 1, 32'(i), 32'(i), 1, (i > 15) ? 4'd15 : 4'(i), (i > 15) ? 4'd15 : 4'(i));
    step("sat_hold",0,0,0,0, 32'h700,      32'h0,        1, 32'h700,      1, 0, 0, 1, 16, 16, 1, 15, 15);
    step("sat_more",0,0,1,1, 32'h704,      32'h2000,     1, 32'h2000,     1, 1, 0, 1, 16, 16, 1, 15, 15);
    step("sat_end", 0,0,0,0, 32'h708,      32'h0,        1, 32'h708,      1, 0, 0, 1, 17, 17, 1, 15, 15);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
